multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the RV32I fetch/decode datapath. It replaces the hand-pushed pc_write/ir_write buttons with generated strobes and drives the register-file, ALU-mux, memory and PC-source controls for one instruction at a time. It supports free-run and single-step modes, counts retired instructions, and traps on unsupported opcodes.

Parameters:
CNT_W, 16, width of retired-instruction counter
TIMEOUT_CYC, 255, mem_ready wait limit in cycles (used only with CTRL_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  level: 1 = free-run, fetch continuously
step  in  1  level; a 0->1 edge (detected internally, 1-cycle registered) starts one instruction from IDLE
opcode  in  7  instruction bits [6:0] from IR decode
br_taken  in  1  branch-compare result from datapath, valid in EXEC
mem_ready  in  1  memory handshake: access done this cycle
pc_write  out  1  PC load strobe
ir_write  out  1  IR load strobe
reg_write  out  1  register-file write strobe
mem_read  out  1  memory read request
mem_write  out  1  memory write request
alu_a_sel  out  2  0=rs1, 1=PC, 2=zero
alu_b_sel  out  1  0=rs2, 1=imm32
wb_sel  out  2  0=ALU, 1=mem data, 2=PC+4
pc_sel  out  2  0=PC+4, 1=PC+imm (branch/JAL), 2=(rs1+imm)&~1 (JALR)
state  out  3  current state code, for LED display
illegal  out  1  sticky trap flag
instr_count  out  CNT_W  retired-instruction count

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Reset, asynchronous: state=IDLE; illegal=0; instr_count=0; step edge register cleared. All strobes low immediately, also when reset arrives mid-instruction.
- Outputs are combinational from state, the latched opcode class, mem_ready and br_taken. Any output not listed for a state is 0.
- IDLE: go to FETCH if run=1, or on a step edge. run has priority when both are active. Step edges in any other state are dropped, not queued.
- FETCH: mem_read=1. When mem_ready=1: ir_write=1, go to DECODE. Otherwise stay.
- DECODE: latch opcode class.
  - Legal opcodes: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC. These go to EXEC.
  - Any other opcode goes to TRAP.
- EXEC ALU selects:
  - R: a=0, b=0.
  - I-ALU/LOAD/STORE/JALR: a=0, b=1.
  - AUIPC: a=1, b=1.
  - LUI: a=2, b=1.
  - BRANCH: a=0, b=0.
- EXEC next state:
  - LOAD/STORE go to MEM.
  - BRANCH retires here: pc_write=1, pc_sel=br_taken?1:0.
  - All other classes go to WB.
- MEM:
  - LOAD: mem_read=1; on mem_ready go to WB.
  - STORE: mem_write=1; on mem_ready retire with pc_write=1, pc_sel=0.
- WB: reg_write=1 and pc_write=1 in the same cycle.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - pc_sel: 1 for JAL, 2 for JALR, 0 otherwise.
- Retire means the cycle in which pc_write=1. On that cycle:
  - instr_count increments; it wraps from 2^CNT_W-1 to 0.
  - Next state is FETCH if run=1, else IDLE.
- TRAP: illegal=1; all strobes 0; PC is not advanced and nothing is counted. Exit only via rst.
- Zero-wait latency (mem_ready held 1), FETCH entry to retire inclusive:
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Handshake: mem_ready is sampled only while mem_read or mem_write is high. mem_ready in the first cycle of FETCH/MEM completes immediately. mem_ready is ignored in other states.
- pc_write and reg_write each assert for exactly one cycle per instruction.

Optional Feature:
CTRL_TIMEOUT_EN
- Defined:
  - A wait counter clears on entry to FETCH/MEM and increments each cycle mem_ready=0.
  - When it reaches TIMEOUT_CYC without a handshake, go to TRAP, set illegal=1 and drop mem_read/mem_write.
  - The counter resets to 0 on rst.
- Undefined: no counter logic is generated; FETCH/MEM wait indefinitely.

Test Plan:
- Reset, run=1, mem_ready=1, IR stream R(0110011), LOAD(0000011), STORE(0100011) -> state sequence 1,2,3,5,1,2,3,4,5,1,2,3,4,1; instr_count=3 after the STORE retires; one pc_write per instruction.
- run=0, step pulses 1 cycle, opcode=0010011 -> exactly one instruction retires, state returns to 0, instr_count=1. A second step pulse issued during EXEC is ignored.
- BRANCH with br_taken=1, then with br_taken=0 -> retire in EXEC with pc_sel=1, then pc_sel=0; reg_write never high.
- JALR in WB -> reg_write=1, wb_sel=2, pc_sel=2, pc_write=1 in the same cycle.
- opcode=1111111 -> TRAP (state=6), illegal=1, instr_count unchanged. Assert rst -> state=0, illegal=0 with no clock edge.
- With CTRL_TIMEOUT_EN and TIMEOUT_CYC=4, mem_ready held 0 in FETCH -> state=6, illegal=1, mem_read=0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for the RV32I multi-cycle sequencer.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             run;
  logic             step;
  logic [6:0]       opcode;
  logic             br_taken;
  logic             mem_ready;
  logic             pc_write;
  logic             ir_write;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic [1:0]       alu_a_sel;
  logic             alu_b_sel;
  logic [1:0]       wb_sel;
  logic [1:0]       pc_sel;
  logic [2:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  run, step, opcode, br_taken, mem_ready,
    output pc_write, ir_write, reg_write, mem_read, mem_write,
           alu_a_sel, alu_b_sel, wb_sel, pc_sel, state, illegal, instr_count
  );

  modport slave (
    output run, step, opcode, br_taken, mem_ready,
    input  pc_write, ir_write, reg_write, mem_read, mem_write,
           alu_a_sel, alu_b_sel, wb_sel, pc_sel, state, illegal, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing, step/run, trap.
// Optional memory-handshake watchdog enabled by defining CTRL_TIMEOUT_EN.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 16
`ifdef CTRL_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [3:0] C_R      = 4'd0;
  localparam logic [3:0] C_IALU   = 4'd1;
  localparam logic [3:0] C_LOAD   = 4'd2;
  localparam logic [3:0] C_STORE  = 4'd3;
  localparam logic [3:0] C_BRANCH = 4'd4;
  localparam logic [3:0] C_JAL    = 4'd5;
  localparam logic [3:0] C_JALR   = 4'd6;
  localparam logic [3:0] C_LUI    = 4'd7;
  localparam logic [3:0] C_AUIPC  = 4'd8;
  localparam logic [3:0] C_ILL    = 4'd9;

  logic [2:0]       state_q, state_d;
  logic [3:0]       cls_q, cls_d;
  logic             step_q;
  logic             step_edge;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       pc_write_c, ir_write_c, reg_write_c, mem_read_c, mem_write_c;
  logic [1:0] alu_a_sel_c, wb_sel_c, pc_sel_c;
  logic       alu_b_sel_c;

  function automatic logic [3:0] decode_cls(input logic [6:0] op);
    case (op)
      7'b0110011: return C_R;
      7'b0010011: return C_IALU;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return C_BRANCH;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      default:    return C_ILL;
    endcase
  endfunction

  assign step_edge = bus.step & ~step_q;

`ifdef CTRL_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              wait_hit;

  // Counts stalled handshake cycles; any other state holds it at zero.
  always_comb begin
    wait_d = '0;
    if ((state_q == S_FETCH || state_q == S_MEM) && !bus.mem_ready)
      wait_d = wait_q + WAIT_W'(1);
  end

  assign wait_hit = (wait_q == WAIT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end
`endif

  // Next state and combinational control strobes.
  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    cnt_d       = cnt_q;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    alu_a_sel_c = 2'd0;
    alu_b_sel_c = 1'b0;
    wb_sel_c    = 2'd0;
    pc_sel_c    = 2'd0;

    case (state_q)
      S_IDLE: begin
        if (bus.run || step_edge) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read_c = 1'b1;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          state_d    = S_DECODE;
        end
`ifdef CTRL_TIMEOUT_EN
        else if (wait_hit) state_d = S_TRAP;
`endif
      end
      S_DECODE: begin
        cls_d   = decode_cls(bus.opcode);
        state_d = (cls_d == C_ILL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        case (cls_q)
          C_IALU, C_LOAD, C_STORE, C_JALR: alu_b_sel_c = 1'b1;
          C_AUIPC: begin
            alu_a_sel_c = 2'd1;
            alu_b_sel_c = 1'b1;
          end
          C_LUI: begin
            alu_a_sel_c = 2'd2;
            alu_b_sel_c = 1'b1;
          end
          default: ;
        endcase
        if (cls_q == C_LOAD || cls_q == C_STORE) begin
          state_d = S_MEM;
        end else if (cls_q == C_BRANCH) begin
          pc_write_c = 1'b1;
          pc_sel_c   = bus.br_taken ? 2'd1 : 2'd0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // Only LOAD and STORE reach this state.
        if (cls_q == C_LOAD) begin
          mem_read_c = 1'b1;
          if (bus.mem_ready) state_d = S_WB;
        end else begin
          mem_write_c = 1'b1;
          if (bus.mem_ready) pc_write_c = 1'b1;
        end
`ifdef CTRL_TIMEOUT_EN
        if (!bus.mem_ready && wait_hit) state_d = S_TRAP;
`endif
      end
      S_WB: begin
        reg_write_c = 1'b1;
        pc_write_c  = 1'b1;
        case (cls_q)
          C_LOAD:  wb_sel_c = 2'd1;
          C_JAL:   wb_sel_c = 2'd2;
          C_JALR:  wb_sel_c = 2'd2;
          default: wb_sel_c = 2'd0;
        endcase
        case (cls_q)
          C_JAL:   pc_sel_c = 2'd1;
          C_JALR:  pc_sel_c = 2'd2;
          default: pc_sel_c = 2'd0;
        endcase
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase

    // Retire: the single pc_write cycle of every instruction.
    if (pc_write_c) begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = bus.run ? S_FETCH : S_IDLE;
    end
  end

  assign illegal_d = illegal_q | (state_d == S_TRAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cls_q     <= C_R;
      step_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      step_q    <= bus.step;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.pc_write    = pc_write_c;
  assign bus.ir_write    = ir_write_c;
  assign bus.reg_write   = reg_write_c;
  assign bus.mem_read    = mem_read_c;
  assign bus.mem_write   = mem_write_c;
  assign bus.alu_a_sel   = alu_a_sel_c;
  assign bus.alu_b_sel   = alu_b_sel_c;
  assign bus.wb_sel      = wb_sel_c;
  assign bus.pc_sel      = pc_sel_c;
  assign bus.state       = state_q;
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction table in step mode,
// free-run sequence, step drop, JALR writeback, trap and async reset.
module tb_multicycle_ctrl;

  localparam int unsigned CW = 3;  // narrow counter so the table run wraps it

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(CW)) bus ();

`ifdef CTRL_TIMEOUT_EN
  multicycle_ctrl #(.CNT_W(CW), .TIMEOUT_CYC(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  multicycle_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  typedef struct {
    logic [6:0] op;
    logic       br;
    int         lat;
    int         a_sel;
    int         b_sel;
    int         wb;
    int         pcs;
    int         rw;
  } vec_t;

  typedef struct packed {
    logic [6:0] op;
    logic       br;
  } ir_t;

  vec_t tbl [10];
  vec_t exp_q [$];
  ir_t  prog_q [$];
  ir_t  ir_e;

  int total, bad, retired;
  int cyc, rw_cnt;
  int ex_a, ex_b;
  logic [2:0] prev_st;

  task automatic chk(input string nm, input longint act, input longint expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Instruction memory model: IR loads the next program word on ir_write.
  always @(posedge clk) begin
    if (bus.ir_write && prog_q.size() > 0) begin
      ir_e = prog_q.pop_front();
      bus.opcode   <= ir_e.op;
      bus.br_taken <= ir_e.br;
    end
  end

  // Scoreboard: every retire pops one expected record.
  always @(negedge clk) begin
    vec_t e;
    if (rst) begin
      cyc = 0; rw_cnt = 0; prev_st = 3'd0;
    end else begin
      if (bus.state == 3'd1 && prev_st != 3'd1) cyc = 1;
      else if (cyc != 0) cyc++;
      if (bus.state == 3'd3) begin
        ex_a = int'(bus.alu_a_sel);
        ex_b = int'(bus.alu_b_sel);
      end
      if (bus.reg_write) rw_cnt++;
      if (bus.pc_write) begin
        chk("retire_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("latency", cyc, e.lat);
          chk("alu_a_sel", ex_a, e.a_sel);
          chk("alu_b_sel", ex_b, e.b_sel);
          chk("wb_sel", bus.wb_sel, e.wb);
          chk("pc_sel", bus.pc_sel, e.pcs);
          chk("reg_write_count", rw_cnt, e.rw);
        end
        retired++;
        cyc = 0;
        rw_cnt = 0;
      end
      prev_st = bus.state;
    end
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_step();
    bus.step = 1'b1;
    @(posedge clk);
    #1;
    bus.step = 1'b0;
  endtask

  task automatic issue(input vec_t v);
    ir_t w;
    w.op = v.op;
    w.br = v.br;
    prog_q.push_back(w);
    exp_q.push_back(v);
  endtask

  task automatic wait_retire(input int target);
    for (int k = 0; k < 30 && retired < target; k++) settle();
    chk("retire_in_time", longint'(retired >= target), 1);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    for (int k = 0; k < budget && bus.state != s; k++) settle();
    chk("reach_state", bus.state, s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [2:0] seq_exp [14];
  logic [2:0] seq_got [14];
  ir_t        bad_op;
  longint     cnt_before;
  int         fetch_cycles;

  initial begin
    total = 0; bad = 0; retired = 0;
    bus.run = 1'b0; bus.step = 1'b0; bus.mem_ready = 1'b1;
    rst = 1'b1;

    //          op          br    lat a  b  wb pcs rw
    tbl[0] = '{7'b0110011, 1'b0, 4, 0, 0, 0, 0, 1};  // R
    tbl[1] = '{7'b0010011, 1'b0, 4, 0, 1, 0, 0, 1};  // I-ALU
    tbl[2] = '{7'b0000011, 1'b0, 5, 0, 1, 1, 0, 1};  // LOAD
    tbl[3] = '{7'b0100011, 1'b0, 4, 0, 1, 0, 0, 0};  // STORE
    tbl[4] = '{7'b1100011, 1'b1, 3, 0, 0, 0, 1, 0};  // BRANCH taken
    tbl[5] = '{7'b1100011, 1'b0, 3, 0, 0, 0, 0, 0};  // BRANCH not taken
    tbl[6] = '{7'b1101111, 1'b0, 4, 0, 0, 2, 1, 1};  // JAL
    tbl[7] = '{7'b1100111, 1'b0, 4, 0, 1, 2, 2, 1};  // JALR
    tbl[8] = '{7'b0110111, 1'b0, 4, 2, 1, 0, 0, 1};  // LUI
    tbl[9] = '{7'b0010111, 1'b0, 4, 1, 1, 0, 0, 1};  // AUIPC
    seq_exp = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                3'd1, 3'd2, 3'd3, 3'd4, 3'd1};

    repeat (2) @(posedge clk);
    #2;
    chk("rst_state", bus.state, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_count", bus.instr_count, 0);
    chk("rst_pc_write", bus.pc_write, 0);
    chk("rst_mem_read", bus.mem_read, 0);
    @(negedge clk);
    rst = 1'b0;
    settle();
    chk("idle_hold", bus.state, 0);

    // Table: each opcode class as one stepped instruction.
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i]);
      pulse_step();
      wait_retire(i + 1);
      settle();
      chk("back_to_idle", bus.state, 0);
      chk("count_wrap", bus.instr_count, (i + 1) % (1 << CW));
    end

    // Free-run R, LOAD, STORE.
    do_reset();
    bus.run = 1'b1;
    issue(tbl[0]);
    issue(tbl[2]);
    issue(tbl[3]);
    for (int j = 0; j < 14; j++) begin
      settle();
      seq_got[j] = bus.state;
    end
    bus.mem_ready = 1'b0;
    bus.run = 1'b0;
    for (int j = 0; j < 14; j++) chk($sformatf("seq_state_%0d", j), seq_got[j], seq_exp[j]);
    chk("freerun_count", bus.instr_count, 3);
    chk("freerun_queue_empty", exp_q.size(), 0);
    settle();
    chk("stall_state", bus.state, 1);
    chk("stall_mem_read", bus.mem_read, 1);
    chk("stall_ir_write", bus.ir_write, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_state", bus.state, 0);
    chk("midrst_mem_read", bus.mem_read, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ready = 1'b1;

    // Second step edge during EXEC is dropped.
    issue(tbl[1]);
    pulse_step();
    wait_state(3'd3, 10);
    bus.step = 1'b1;
    settle();
    bus.step = 1'b0;
    repeat (6) settle();
    chk("step_drop_state", bus.state, 0);
    chk("step_drop_count", bus.instr_count, 1);
    chk("step_drop_queue", exp_q.size(), 0);

    // JALR writeback: all WB controls in one cycle.
    issue(tbl[7]);
    pulse_step();
    wait_state(3'd5, 10);
    chk("jalr_reg_write", bus.reg_write, 1);
    chk("jalr_pc_write", bus.pc_write, 1);
    chk("jalr_wb_sel", bus.wb_sel, 2);
    chk("jalr_pc_sel", bus.pc_sel, 2);
    settle();

    // Illegal opcode traps; only reset leaves TRAP.
    cnt_before = longint'(bus.instr_count);
    bad_op.op = 7'b1111111;
    bad_op.br = 1'b0;
    prog_q.push_back(bad_op);
    pulse_step();
    wait_state(3'd6, 10);
    chk("trap_illegal", bus.illegal, 1);
    chk("trap_count", bus.instr_count, cnt_before);
    chk("trap_pc_write", bus.pc_write, 0);
    chk("trap_mem_read", bus.mem_read, 0);
    bus.run = 1'b1;
    pulse_step();
    repeat (3) settle();
    chk("trap_sticky", bus.state, 6);
    bus.run = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("trap_rst_state", bus.state, 0);
    chk("trap_rst_illegal", bus.illegal, 0);
    @(negedge clk);
    rst = 1'b0;

`ifdef CTRL_TIMEOUT_EN
    // Handshake watchdog: FETCH without mem_ready traps after 4 cycles.
    bus.mem_ready = 1'b0;
    bus.run = 1'b1;
    fetch_cycles = 0;
    for (int k = 0; k < 12 && bus.state != 3'd6; k++) begin
      settle();
      if (bus.state == 3'd1) fetch_cycles++;
    end
    chk("to_state", bus.state, 6);
    chk("to_illegal", bus.illegal, 1);
    chk("to_mem_read", bus.mem_read, 0);
    chk("to_fetch_cycles", fetch_cycles, 4);
    bus.run = 1'b0;
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
